ysyx_22050368_wbck: RTL and testbench

Write-back arbiter and staging register that drives the integer register file's write port. Two result sources compete for the single write port and are merged into one registered write stage:
- **ALU:** single-cycle results.
- **LSU:** long-latency load and multiply/divide results.

The block also gives decode two bypass ports covering the cycle in which a staged write is not yet visible in the register file.

---
 rtl/ysyx_22050368_wbck_pkg.sv | 15 +
 rtl/sirv_gnrl_dfflr.sv | 24 ++
 rtl/ysyx_22050368_wbck.sv | 128 ++++++++++++
 tb/tb_ysyx_22050368_wbck.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050368_wbck_pkg.sv
// Shared widths and types for the write-back stage.
package ysyx_22050368_wbck_pkg;

    localparam int unsigned DefXlen       = 64;
    localparam int unsigned DefRfidxWidth = 5;
    localparam int unsigned DefStarveMax  = 4;
    localparam int unsigned CntWidth      = 4;

    typedef enum logic [1:0] {
        SrcNone,
        SrcAlu,
        SrcLsu
    } wbck_src_e;

endpackage

// File: rtl/sirv_gnrl_dfflr.sv
// Load-enabled flop with asynchronous active-low reset to zero.
module sirv_gnrl_dfflr #(
    parameter int unsigned DW = 32
) (
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout,
    input  logic          clk,
    input  logic          rst_n
);

    logic [DW-1:0] qout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qout_q <= '0;
        end else if (lden) begin
            qout_q <= dnxt;
        end
    end

    assign qout = qout_q;

endmodule

// File: rtl/ysyx_22050368_wbck.sv
// Write-back arbiter (LSU priority, ALU anti-starvation) feeding one registered
// register-file write port, plus decode bypass of the staged write.
module ysyx_22050368_wbck
    import ysyx_22050368_wbck_pkg::*;
#(
    parameter int unsigned XLEN        = DefXlen,
    parameter int unsigned RFIDX_WIDTH = DefRfidxWidth,
    parameter int unsigned STARVE_MAX  = DefStarveMax
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   alu_wbck_valid,
    output logic                   alu_wbck_ready,
    input  logic [RFIDX_WIDTH-1:0] alu_wbck_idx,
    input  logic [XLEN-1:0]        alu_wbck_dat,

    input  logic                   lsu_wbck_valid,
    output logic                   lsu_wbck_ready,
    input  logic [RFIDX_WIDTH-1:0] lsu_wbck_idx,
    input  logic [XLEN-1:0]        lsu_wbck_dat,

    output logic                   wbck_dest_wen,
    output logic [RFIDX_WIDTH-1:0] wbck_dest_idx,
    output logic [XLEN-1:0]        wbck_dest_dat,

    input  logic [RFIDX_WIDTH-1:0] byp_rs1_idx,
    input  logic [RFIDX_WIDTH-1:0] byp_rs2_idx,
    output logic                   byp_rs1_hit,
    output logic                   byp_rs2_hit,
    output logic [XLEN-1:0]        byp_rs1_dat,
    output logic [XLEN-1:0]        byp_rs2_dat
);

    localparam logic [CntWidth-1:0] StarveMaxCnt = CntWidth'(STARVE_MAX);

    logic                   force_alu;
    wbck_src_e              src;
    logic [RFIDX_WIDTH-1:0] sel_idx;
    logic [XLEN-1:0]        sel_dat;
    logic                   wen_d;
    logic                   wen_q;
    logic [RFIDX_WIDTH-1:0] idx_q;
    logic [XLEN-1:0]        dat_q;
    logic [CntWidth-1:0]    starve_cnt_d;
    logic [CntWidth-1:0]    starve_cnt_q;

    assign force_alu = (starve_cnt_q == StarveMaxCnt);

    always_comb begin
        lsu_wbck_ready = lsu_wbck_valid & ~force_alu;
        alu_wbck_ready = alu_wbck_valid & (~lsu_wbck_valid | force_alu);

        src = SrcNone;
        if (lsu_wbck_ready) begin
            src = SrcLsu;
        end else if (alu_wbck_ready) begin
            src = SrcAlu;
        end

        sel_idx = '0;
        sel_dat = '0;
        unique case (src)
            SrcLsu: begin
                sel_idx = lsu_wbck_idx;
                sel_dat = lsu_wbck_dat;
            end
            SrcAlu: begin
                sel_idx = alu_wbck_idx;
                sel_dat = alu_wbck_dat;
            end
            default: ;
        endcase

        // x0 writes are acknowledged but never reach the register file
        wen_d = (src != SrcNone) && (sel_idx != '0);

        starve_cnt_d = starve_cnt_q;
        if (!alu_wbck_valid || alu_wbck_ready) begin
            starve_cnt_d = '0;
        end else if (lsu_wbck_valid && !force_alu) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    sirv_gnrl_dfflr #(.DW(1)) u_wen_dff (
        .lden  (1'b1),
        .dnxt  (wen_d),
        .qout  (wen_q),
        .clk   (clk),
        .rst_n (rst_n)
    );

    sirv_gnrl_dfflr #(.DW(RFIDX_WIDTH)) u_idx_dff (
        .lden  (wen_d),
        .dnxt  (sel_idx),
        .qout  (idx_q),
        .clk   (clk),
        .rst_n (rst_n)
    );

    sirv_gnrl_dfflr #(.DW(XLEN)) u_dat_dff (
        .lden  (wen_d),
        .dnxt  (sel_dat),
        .qout  (dat_q),
        .clk   (clk),
        .rst_n (rst_n)
    );

    sirv_gnrl_dfflr #(.DW(CntWidth)) u_cnt_dff (
        .lden  (1'b1),
        .dnxt  (starve_cnt_d),
        .qout  (starve_cnt_q),
        .clk   (clk),
        .rst_n (rst_n)
    );

    assign wbck_dest_wen = wen_q;
    assign wbck_dest_idx = idx_q;
    assign wbck_dest_dat = dat_q;

    // wen is only ever set for a nonzero index, so a hit on x0 is impossible
    assign byp_rs1_hit = wen_q & (byp_rs1_idx == idx_q);
    assign byp_rs2_hit = wen_q & (byp_rs2_idx == idx_q);
    assign byp_rs1_dat = dat_q;
    assign byp_rs2_dat = dat_q;

endmodule

// File: tb/tb_ysyx_22050368_wbck.sv
// Directed bench for ysyx_22050368_wbck with STARVE_MAX = 4.
module tb_ysyx_22050368_wbck;

    logic        clk;
    logic        rst_n;
    logic        alu_wbck_valid;
    logic        alu_wbck_ready;
    logic [4:0]  alu_wbck_idx;
    logic [63:0] alu_wbck_dat;
    logic        lsu_wbck_valid;
    logic        lsu_wbck_ready;
    logic [4:0]  lsu_wbck_idx;
    logic [63:0] lsu_wbck_dat;
    logic        wbck_dest_wen;
    logic [4:0]  wbck_dest_idx;
    logic [63:0] wbck_dest_dat;
    logic [4:0]  byp_rs1_idx;
    logic [4:0]  byp_rs2_idx;
    logic        byp_rs1_hit;
    logic        byp_rs2_hit;
    logic [63:0] byp_rs1_dat;
    logic [63:0] byp_rs2_dat;

    int errors = 0;
    int checks = 0;

    ysyx_22050368_wbck dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_wbck_valid (alu_wbck_valid),
        .alu_wbck_ready (alu_wbck_ready),
        .alu_wbck_idx   (alu_wbck_idx),
        .alu_wbck_dat   (alu_wbck_dat),
        .lsu_wbck_valid (lsu_wbck_valid),
        .lsu_wbck_ready (lsu_wbck_ready),
        .lsu_wbck_idx   (lsu_wbck_idx),
        .lsu_wbck_dat   (lsu_wbck_dat),
        .wbck_dest_wen  (wbck_dest_wen),
        .wbck_dest_idx  (wbck_dest_idx),
        .wbck_dest_dat  (wbck_dest_dat),
        .byp_rs1_idx    (byp_rs1_idx),
        .byp_rs2_idx    (byp_rs2_idx),
        .byp_rs1_hit    (byp_rs1_hit),
        .byp_rs2_hit    (byp_rs2_hit),
        .byp_rs1_dat    (byp_rs1_dat),
        .byp_rs2_dat    (byp_rs2_dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        alu_wbck_valid = 1'b0;
        alu_wbck_idx   = '0;
        alu_wbck_dat   = '0;
        lsu_wbck_valid = 1'b0;
        lsu_wbck_idx   = '0;
        lsu_wbck_dat   = '0;
        byp_rs1_idx    = '0;
        byp_rs2_idx    = '0;

        // Reset state
        #8;
        chk("rst_wen", 64'(wbck_dest_wen), 64'd0);
        chk("rst_idx", 64'(wbck_dest_idx), 64'd0);
        chk("rst_dat", wbck_dest_dat, 64'd0);
        chk("rst_alu_rdy", 64'(alu_wbck_ready), 64'd0);
        chk("rst_lsu_rdy", 64'(lsu_wbck_ready), 64'd0);
        #4 rst_n = 1'b1;
        tick();

        // Single ALU write and bypass
        alu_wbck_valid = 1'b1;
        alu_wbck_idx   = 5'd5;
        alu_wbck_dat   = 64'h1234;
        byp_rs1_idx    = 5'd5;
        #1;
        chk("single_alu_rdy", 64'(alu_wbck_ready), 64'd1);
        chk("single_lsu_rdy", 64'(lsu_wbck_ready), 64'd0);
        tick();
        alu_wbck_valid = 1'b0;
        chk("single_wen", 64'(wbck_dest_wen), 64'd1);
        chk("single_idx", 64'(wbck_dest_idx), 64'd5);
        chk("single_dat", wbck_dest_dat, 64'h1234);
        chk("single_hit", 64'(byp_rs1_hit), 64'd1);
        chk("single_bdat", byp_rs1_dat, 64'h1234);
        tick();
        chk("single_wen_off", 64'(wbck_dest_wen), 64'd0);
        chk("single_idx_keep", 64'(wbck_dest_idx), 64'd5);
        chk("single_hit_off", 64'(byp_rs1_hit), 64'd0);

        // Conflict: LSU first, then ALU once LSU drops
        alu_wbck_valid = 1'b1;
        alu_wbck_idx   = 5'd3;
        alu_wbck_dat   = 64'h33;
        lsu_wbck_valid = 1'b1;
        lsu_wbck_idx   = 5'd7;
        lsu_wbck_dat   = 64'h77;
        #1;
        chk("conf_lsu_rdy", 64'(lsu_wbck_ready), 64'd1);
        chk("conf_alu_rdy0", 64'(alu_wbck_ready), 64'd0);
        tick();
        lsu_wbck_valid = 1'b0;
        #1;
        chk("conf_idx_lsu", 64'(wbck_dest_idx), 64'd7);
        chk("conf_dat_lsu", wbck_dest_dat, 64'h77);
        chk("conf_alu_rdy1", 64'(alu_wbck_ready), 64'd1);
        tick();
        alu_wbck_valid = 1'b0;
        chk("conf_idx_alu", 64'(wbck_dest_idx), 64'd3);
        chk("conf_dat_alu", wbck_dest_dat, 64'h33);

        // Starvation: LSU cycles 0..3, ALU cycle 4, LSU again cycle 5
        alu_wbck_valid = 1'b1;
        alu_wbck_idx   = 5'd4;
        alu_wbck_dat   = 64'h44;
        lsu_wbck_valid = 1'b1;
        lsu_wbck_idx   = 5'd10;
        for (int i = 0; i < 6; i++) begin
            lsu_wbck_dat = 64'hA0 + 64'(i);
            if (i == 5) begin
                alu_wbck_idx = 5'd6;
                alu_wbck_dat = 64'h66;
            end
            #1;
            chk($sformatf("starve_lsu_rdy%0d", i), 64'(lsu_wbck_ready), (i == 4) ? 64'd0 : 64'd1);
            chk($sformatf("starve_alu_rdy%0d", i), 64'(alu_wbck_ready), (i == 4) ? 64'd1 : 64'd0);
            tick();
            if (i == 0) chk("starve_dat0", wbck_dest_dat, 64'hA0);
            if (i == 4) chk("starve_idx4", 64'(wbck_dest_idx), 64'd4);
        end
        lsu_wbck_valid = 1'b0;
        chk("starve_idx5", 64'(wbck_dest_idx), 64'd10);
        chk("starve_dat5", wbck_dest_dat, 64'hA5);

        // x0 write is acknowledged but dropped
        alu_wbck_idx = 5'd0;
        alu_wbck_dat = 64'hFFFF;
        byp_rs1_idx  = 5'd0;
        #1;
        chk("x0_rdy", 64'(alu_wbck_ready), 64'd1);
        tick();
        alu_wbck_valid = 1'b0;
        chk("x0_wen", 64'(wbck_dest_wen), 64'd0);
        chk("x0_hit", 64'(byp_rs1_hit), 64'd0);
        chk("x0_idx_keep", 64'(wbck_dest_idx), 64'd10);
        chk("x0_dat_keep", wbck_dest_dat, 64'hA5);

        // Build up starvation count, then reset mid-cycle
        alu_wbck_valid = 1'b1;
        alu_wbck_idx   = 5'd12;
        alu_wbck_dat   = 64'hC;
        lsu_wbck_valid = 1'b1;
        lsu_wbck_idx   = 5'd13;
        lsu_wbck_dat   = 64'hD;
        tick();
        tick();
        tick();
        chk("prerst_wen", 64'(wbck_dest_wen), 64'd1);
        alu_wbck_valid = 1'b0;
        lsu_wbck_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_wen", 64'(wbck_dest_wen), 64'd0);
        chk("midrst_idx", 64'(wbck_dest_idx), 64'd0);
        chk("midrst_dat", wbck_dest_dat, 64'd0);
        #1 rst_n = 1'b1;

        // Counter must restart from zero: four LSU grants before the ALU
        alu_wbck_valid = 1'b1;
        lsu_wbck_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("postrst_lsu_rdy%0d", i), 64'(lsu_wbck_ready), (i == 4) ? 64'd0 : 64'd1);
            chk($sformatf("postrst_alu_rdy%0d", i), 64'(alu_wbck_ready), (i == 4) ? 64'd1 : 64'd0);
            tick();
            if (i == 0) begin
                chk("postrst_wen", 64'(wbck_dest_wen), 64'd1);
                chk("postrst_idx", 64'(wbck_dest_idx), 64'd13);
            end
        end
        alu_wbck_valid = 1'b0;
        lsu_wbck_valid = 1'b0;
        chk("postrst_alu_idx", 64'(wbck_dest_idx), 64'd12);
        tick();

        // Back-to-back writes to the same index
        alu_wbck_valid = 1'b1;
        alu_wbck_idx   = 5'd9;
        alu_wbck_dat   = 64'd1;
        byp_rs2_idx    = 5'd9;
        tick();
        alu_wbck_dat = 64'd2;
        chk("b2b_hit1", 64'(byp_rs2_hit), 64'd1);
        chk("b2b_dat1", byp_rs2_dat, 64'd1);
        tick();
        alu_wbck_valid = 1'b0;
        chk("b2b_hit2", 64'(byp_rs2_hit), 64'd1);
        chk("b2b_dat2", byp_rs2_dat, 64'd2);
        chk("b2b_wdat", wbck_dest_dat, 64'd2);
        tick();
        chk("b2b_wen_off", 64'(wbck_dest_wen), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
